wb_port_arbiter: RTL and testbench

Sequential arbiter for the single register-file write port at the end of the pipeline. Three result producers compete for that port each cycle: the ALU path, the load path from data memory and the multiply/divide unit (MDU). The block grants one producer per cycle by round-robin and registers the winning write. It also keeps a pending-write scoreboard so decode can stall on registers still owed by multi-cycle operations.

---
 rtl/wb_pkg.sv | 23 ++
 rtl/rr_arbiter3.sv | 33 +++
 rtl/wb_port_arbiter.sv | 107 ++++++++++
 tb/tb_wb_port_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback-port arbiter: requester indices and the round-robin pointer.
// Pure declarations; no latency or backpressure of its own.
package wb_pkg;

  typedef logic [1:0] ptr_t;

  localparam int   NUM_REQ = 3;
  localparam ptr_t REQ_ALU = 2'd0;
  localparam ptr_t REQ_MEM = 2'd1;
  localparam ptr_t REQ_MDU = 2'd2;

  // Successor in the ALU -> MEM -> MDU ring; the unused encoding 3 folds back to ALU.
  function automatic ptr_t nextPtr(input ptr_t idx);
    ptr_t res;
    if (idx >= REQ_MDU) begin
      res = REQ_ALU;
    end else begin
      res = idx + 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Combinational three-way round-robin pick starting at the pointer; zero latency.
// Grants at most one request, and only one that is asserted; holds no state.
module rr_arbiter3
  import wb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  ptr_t               ptr,
  output logic [NUM_REQ-1:0] grant,
  output ptr_t               winner,
  output logic               anyGrant
);

  ptr_t idx;
  logic found;

  always_comb begin
    grant  = '0;
    winner = REQ_ALU;
    found  = 1'b0;
    idx    = (ptr > REQ_MDU) ? REQ_ALU : ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        winner     = idx;
        found      = 1'b1;
      end
      idx = nextPtr(idx);
    end
  end

  assign anyGrant = |req;

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter for the register-file write port with a pending-write scoreboard; write appears one cycle after the handshake.
// Losers see ready low and hold their request; every ready is forced low while rst is high.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int data_len = 32,
  parameter int addr_len = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  input  logic [addr_len-1:0]    alu_rd,
  input  logic [data_len-1:0]    alu_data,
  output logic                   alu_ready,
  input  logic                   mem_valid,
  input  logic [addr_len-1:0]    mem_rd,
  input  logic [data_len-1:0]    mem_data,
  output logic                   mem_ready,
  input  logic                   mdu_valid,
  input  logic [addr_len-1:0]    mdu_rd,
  input  logic [data_len-1:0]    mdu_data,
  output logic                   mdu_ready,
  input  logic                   lock_valid,
  input  logic [addr_len-1:0]    lock_rd,
  output logic                   RegWrite,
  output logic [addr_len-1:0]    writeReg,
  output logic [data_len-1:0]    writeData,
  output logic [2**addr_len-1:0] pending
);

  localparam int NUM_REGS = 2**addr_len;

  ptr_t                ptr;
  ptr_t                winner;
  logic [NUM_REQ-1:0]  reqVec;
  logic [NUM_REQ-1:0]  grant;
  logic                anyGrant;
  logic [addr_len-1:0] selRd;
  logic [data_len-1:0] selData;
  logic [NUM_REGS-1:0] pendingNext;

  assign reqVec = {mdu_valid, mem_valid, alu_valid};

  rr_arbiter3 u_rr (
    .req      (reqVec),
    .ptr      (ptr),
    .grant    (grant),
    .winner   (winner),
    .anyGrant (anyGrant)
  );

  assign alu_ready = grant[REQ_ALU] & ~rst;
  assign mem_ready = grant[REQ_MEM] & ~rst;
  assign mdu_ready = grant[REQ_MDU] & ~rst;

  always_comb begin
    selRd   = alu_rd;
    selData = alu_data;
    case (winner)
      REQ_MEM: begin
        selRd   = mem_rd;
        selData = mem_data;
      end
      REQ_MDU: begin
        selRd   = mdu_rd;
        selData = mdu_data;
      end
      default: begin
        selRd   = alu_rd;
        selData = alu_data;
      end
    endcase
  end

  // Clear first so a lock issued in the same cycle re-arms the bit.
  always_comb begin
    pendingNext = pending;
    if (anyGrant && winner != REQ_ALU) begin
      pendingNext[selRd] = 1'b0;
    end
    if (lock_valid && lock_rd != '0) begin
      pendingNext[lock_rd] = 1'b1;
    end
    pendingNext[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= REQ_ALU;
      RegWrite  <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
      pending   <= '0;
    end else begin
      pending <= pendingNext;
      if (anyGrant) begin
        ptr       <= nextPtr(winner);
        RegWrite  <= (selRd != '0);
        writeReg  <= selRd;
        writeData <= selData;
      end else begin
        RegWrite <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: hand-computed grants, write-port values and scoreboard bits.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid, mdu_valid, lock_valid;
  logic [4:0]  alu_rd, mem_rd, mdu_rd, lock_rd;
  logic [31:0] alu_data, mem_data, mdu_data;
  logic        alu_ready, mem_ready, mdu_ready;
  logic        RegWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [31:0] pending;

  int checks = 0;
  int failures = 0;

  wb_port_arbiter #(.data_len(32), .addr_len(5)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .lock_valid(lock_valid), .lock_rd(lock_rd),
    .RegWrite(RegWrite), .writeReg(writeReg), .writeData(writeData), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; mem_valid = 0; mdu_valid = 0; lock_valid = 0;
  endtask

  function automatic logic [2:0] rdys();
    return {mdu_ready, mem_ready, alu_ready};
  endfunction

  initial begin
    rst = 1; idle();
    alu_rd = 0; mem_rd = 0; mdu_rd = 0; lock_rd = 0;
    alu_data = 0; mem_data = 0; mdu_data = 0;

    // reset state, readies forced low even with requests present
    #2;
    mem_valid = 1; alu_valid = 1;
    #1;
    checkVal("rst_ready", rdys(), 3'b000);
    checkVal("rst_regwrite", RegWrite, 0);
    checkVal("rst_writereg", writeReg, 0);
    checkVal("rst_writedata", writeData, 0);
    checkVal("rst_pending", pending, 0);
    idle();
    tick(); tick();
    rst = 0;

    // single ALU write rd=5
    alu_valid = 1; alu_rd = 5; alu_data = 32'hAA;
    #1;
    checkVal("t1_ready", rdys(), 3'b001);
    tick();
    idle();
    checkVal("t1_regwrite", RegWrite, 1);
    checkVal("t1_writereg", writeReg, 5);
    checkVal("t1_writedata", writeData, 32'hAA);
    tick();
    checkVal("t1_regwrite_drop", RegWrite, 0);

    // all three continuously valid from reset
    rst = 1;
    #1;
    alu_valid = 1; alu_rd = 1; alu_data = 32'h11;
    mem_valid = 1; mem_rd = 2; mem_data = 32'h22;
    mdu_valid = 1; mdu_rd = 3; mdu_data = 32'h33;
    tick();
    rst = 0;
    #1;
    for (int i = 0; i < 4; i++) begin
      logic [2:0] expRdy;
      logic [4:0] expRd;
      logic [31:0] expData;
      expRdy = 3'b001 << (i % 3);
      expRd = 5'(i % 3 + 1);
      expData = 32'h11 * (i % 3 + 1);
      checkVal($sformatf("rr_ready%0d", i), rdys(), expRdy);
      tick();
      checkVal($sformatf("rr_writereg%0d", i), writeReg, expRd);
      checkVal($sformatf("rr_writedata%0d", i), writeData, expData);
      checkVal($sformatf("rr_regwrite%0d", i), RegWrite, 1);
    end
    idle();
    // pointer now at MEM

    // MEM write to r0: handshake but no RegWrite
    mem_valid = 1; mem_rd = 0; mem_data = 32'h1234;
    #1;
    checkVal("r0_ready", rdys(), 3'b010);
    tick();
    idle();
    checkVal("r0_regwrite", RegWrite, 0);
    checkVal("r0_writedata", writeData, 32'h1234);
    // pointer now at MDU

    // scoreboard: lock r8, ALU write keeps it, MEM grant clears it
    lock_valid = 1; lock_rd = 8;
    #1;
    checkVal("sb_pre", pending, 0);
    tick();
    lock_valid = 0;
    checkVal("sb_set8", pending, 32'h0000_0100);
    alu_valid = 1; alu_rd = 8; alu_data = 32'hBEEF;
    #1;
    checkVal("sb_alu_ready", rdys(), 3'b001);
    tick();
    idle();
    checkVal("sb_alu_writereg", writeReg, 8);
    checkVal("sb_alu_keeps8", pending, 32'h0000_0100);
    mem_valid = 1; mem_rd = 8; mem_data = 32'h55;
    #1;
    checkVal("sb_mem_ready", rdys(), 3'b010);
    checkVal("sb_still8", pending, 32'h0000_0100);
    tick();
    idle();
    checkVal("sb_mem_regwrite", RegWrite, 1);
    checkVal("sb_clear8", pending, 0);
    // pointer now at MDU

    // simultaneous set and clear on r9
    lock_valid = 1; lock_rd = 9;
    tick();
    checkVal("sc_set9", pending, 32'h0000_0200);
    mdu_valid = 1; mdu_rd = 9; mdu_data = 32'h99;
    lock_valid = 1; lock_rd = 9;
    #1;
    checkVal("sc_mdu_ready", rdys(), 3'b100);
    tick();
    idle();
    checkVal("sc_set_wins", pending, 32'h0000_0200);
    checkVal("sc_writereg", writeReg, 9);
    // pointer at ALU; MDU alone now clears r9 while r4 gets locked
    mdu_valid = 1; mdu_rd = 9; mdu_data = 32'h77;
    lock_valid = 1; lock_rd = 4;
    #1;
    checkVal("sc_mdu2_ready", rdys(), 3'b100);
    tick();
    idle();
    checkVal("sc_clear9_set4", pending, 32'h0000_0010);
    checkVal("sc_writedata2", writeData, 32'h77);
    // pointer at ALU

    // reset mid-stream with MEM and MDU requesting
    mem_valid = 1; mem_rd = 6; mem_data = 32'h66;
    mdu_valid = 1; mdu_rd = 10; mdu_data = 32'hAB;
    #1;
    checkVal("mr_pre_ready", rdys(), 3'b010);
    rst = 1;
    #1;
    checkVal("mr_ready", rdys(), 3'b000);
    checkVal("mr_regwrite", RegWrite, 0);
    checkVal("mr_writereg", writeReg, 0);
    checkVal("mr_writedata", writeData, 0);
    checkVal("mr_pending", pending, 0);
    tick();
    rst = 0;
    alu_valid = 1; alu_rd = 7; alu_data = 32'hC0DE;
    #1;
    checkVal("mr_alu_first", rdys(), 3'b001);
    tick();
    checkVal("mr_writereg7", writeReg, 7);
    checkVal("mr_next_mem", rdys(), 3'b010);
    tick();
    idle();
    checkVal("mr_writereg6", writeReg, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
